// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encodings and block geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  // 2-bit state encoding shared by the arbiter FSM.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_I_FILL  = 2'd1,
    ST_D_FILL  = 2'd2,
    ST_D_WRITE = 2'd3
  } state_t;

  localparam int BLOCK_BYTES         = 16;
  // Byte-offset bits within a block; cleared to form the block base address.
  localparam int OFFSET_MASK         = BLOCK_BYTES - 1;
  localparam int WORDS_PER_BLOCK_DEF = 8;

endpackage

// File: rtl/block_sequencer.sv
// Block fill sequencer: issue and receive word counters with address generation.
// Latency: counters advance one step per enabled cycle; addresses are combinational.
// Backpressure: none; the issue side stops by itself once all words are issued.
//
// Ports: clr zeroes both counters (on grant); issue_en / rcv_en advance them;
// base is the block base address; issue_addr / rcv_addr = base + 2*count;
// rcv_last flags the final word; issue_done is set after the final issue.
module block_sequencer
  import mem_arbiter_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              issue_en,
  input  logic              rcv_en,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] issue_addr,
  output logic [ADDR_W-1:0] rcv_addr,
  output logic              rcv_last,
  output logic              issue_done
);

  localparam int CNT_W = $clog2(WORDS_PER_BLOCK);

  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] rcv_cnt;
  logic             issue_last;

  assign issue_last = (issue_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
  assign rcv_last   = (rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

  // Words are 2 bytes, so the count is shifted left by one into the offset.
  assign issue_addr = base + ADDR_W'({issue_cnt, 1'b0});
  assign rcv_addr   = base + ADDR_W'({rcv_cnt, 1'b0});

  // Counters are power-of-two wide, so they wrap to 0 after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      issue_done <= 1'b0;
    end else if (clr) begin
      issue_cnt  <= '0;
      rcv_cnt    <= '0;
      issue_done <= 1'b0;
    end else begin
      if (issue_en) begin
        issue_cnt <= issue_cnt + 1'b1;
        if (issue_last) issue_done <= 1'b1;
      end
      if (rcv_en) rcv_cnt <= rcv_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory between I-cache and D-cache: block fills and D write-through.
// Latency: grant 1 cycle after request; fill done 8+L cycles after grant-1; write done in grant cycle.
// Backpressure: requesters are held via i_stall/d_stall until their done pulse.
//
// Ports: i_req/i_addr and d_req/d_addr/d_wr/d_wdata are level requests;
// mem_* is the memory access port (mem_valid returns reads in order);
// fill_data/fill_addr with i_fill_we/d_fill_we write the cache; *_done pulse on completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [15:0]       d_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       fill_data,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_done,
  output logic              d_done,
  output logic              i_stall,
  output logic              d_stall
);

  state_t            state, next_state;
  logic              last_grant;   // 1 = D side was granted most recently
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              grant_i, grant_d;
  logic              issue_en, rcv_en, fill_vld;
  logic [ADDR_W-1:0] base, issue_addr, rcv_addr;
  logic              rcv_last, issue_done;

  assign base = addr_q & ~ADDR_W'(OFFSET_MASK);

  block_sequencer #(
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
    .ADDR_W         (ADDR_W)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (grant_i | grant_d),
    .issue_en  (issue_en),
    .rcv_en    (rcv_en),
    .base      (base),
    .issue_addr(issue_addr),
    .rcv_addr  (rcv_addr),
    .rcv_last  (rcv_last),
    .issue_done(issue_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= next_state;
      if (grant_d) begin
        addr_q     <= d_addr;
        wdata_q    <= d_wdata;
        last_grant <= 1'b1;
      end else if (grant_i) begin
        addr_q     <= i_addr;
        last_grant <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    issue_en   = 1'b0;
    rcv_en     = 1'b0;
    fill_vld   = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      ST_IDLE: begin
        // On a tie the side that did not win last time goes first.
        grant_d = d_req & (~i_req | ~last_grant);
        grant_i = i_req & ~grant_d;
        if (grant_d)      next_state = d_wr ? ST_D_WRITE : ST_D_FILL;
        else if (grant_i) next_state = ST_I_FILL;
      end
      ST_I_FILL, ST_D_FILL: begin
        issue_en = ~issue_done;
        mem_en   = ~issue_done;
        mem_addr = issue_done ? '0 : issue_addr;
        rcv_en   = mem_valid;
        fill_vld = mem_valid;
        if (mem_valid && rcv_last) begin
          if (state == ST_D_FILL) d_done = 1'b1;
          else                    i_done = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_D_WRITE: begin
        mem_en     = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        d_done     = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Fill outputs are zero outside a returning word so stale data never leaks out.
  assign i_fill_we = fill_vld & (state == ST_I_FILL);
  assign d_fill_we = fill_vld & (state == ST_D_FILL);
  assign fill_data = fill_vld ? mem_rdata : 16'h0000;
  assign fill_addr = fill_vld ? rcv_addr : '0;

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] fill_data, fill_addr;
  logic        i_fill_we, d_fill_we, i_done, d_done, i_stall, d_stall;
  logic        inj_valid;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_addr(fill_addr),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_done(i_done), .d_done(d_done),
    .i_stall(i_stall), .d_stall(d_stall)
  );

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Memory with fixed read latency; not reset, so in-flight reads survive a DUT reset.
  logic [MEM_LAT-1:0] sr_v = '0;
  logic [15:0]        sr_a [MEM_LAT];
  always @(posedge clk) begin
    sr_v    <= {sr_v[MEM_LAT-2:0], mem_en & ~mem_wr};
    sr_a[0] <= mem_addr;
    for (int s = 1; s < MEM_LAT; s++) sr_a[s] <= sr_a[s-1];
  end
  assign mem_valid = sr_v[MEM_LAT-1] | inj_valid;
  assign mem_rdata = inj_valid ? 16'hDEAD :
                     (sr_v[MEM_LAT-1] ? mem_model(sr_a[MEM_LAT-1]) : 16'h0000);

  int n_chk = 0, n_fail = 0, cur_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cur_cyc, act, exp);
    end
  endtask

  // Scoreboard of expected cache fills, consumed whenever a fill_we appears.
  typedef struct { bit is_d; logic [15:0] addr; logic [15:0] data; } fill_t;
  fill_t sb[$];

  always @(negedge clk) begin
    if (i_fill_we || d_fill_we) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL fill_unexpected cycle %0d: got i_we=%0b d_we=%0b addr=0x%0h expected no fill",
                 cur_cyc, i_fill_we, d_fill_we, fill_addr);
      end else begin
        fill_t e;
        e = sb.pop_front();
        chk("fill_side", {30'd0, i_fill_we, d_fill_we}, e.is_d ? 32'd1 : 32'd2);
        chk("fill_addr", fill_addr, e.addr);
        chk("fill_data", fill_data, e.data);
      end
    end
  end

  typedef struct { int start; bit is_d; bit wr; logic [15:0] addr; logic [15:0] base; logic [15:0] wdata; } op_t;
  typedef struct { int cyc; bit is_d; bit on; logic [15:0] addr; bit wr; logic [15:0] wdata; } ev_t;
  op_t ops[$];
  ev_t evs[$];

  task automatic add_op(input int st, input bit is_d, input bit wr, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] wd);
    op_t o;
    o.start = st; o.is_d = is_d; o.wr = wr; o.addr = a; o.base = b; o.wdata = wd;
    ops.push_back(o);
  endtask

  task automatic add_ev(input int c, input bit is_d, input bit on, input logic [15:0] a,
                        input bit wr, input logic [15:0] wd);
    ev_t e;
    e.cyc = c; e.is_d = is_d; e.on = on; e.addr = a; e.wr = wr; e.wdata = wd;
    evs.push_back(e);
  endtask

  // Expected outputs for cycle c from the list of scheduled operations.
  task automatic check_cycle(input int c);
    logic e_en, e_wr, e_ifwe, e_dfwe, e_idone, e_ddone;
    logic [15:0] e_addr, e_wd;
    int k;
    e_en = 0; e_wr = 0; e_ifwe = 0; e_dfwe = 0; e_idone = 0; e_ddone = 0;
    e_addr = 16'h0; e_wd = 16'h0;
    cur_cyc = c;
    foreach (ops[j]) begin
      k = c - ops[j].start;
      if (ops[j].wr) begin
        if (k == 0) begin
          e_en = 1; e_wr = 1; e_addr = ops[j].addr; e_wd = ops[j].wdata; e_ddone = 1;
        end
      end else begin
        if (k >= 0 && k < 8) begin e_en = 1; e_addr = ops[j].base + 16'(2 * k); end
        if (k >= MEM_LAT && k < MEM_LAT + 8) begin
          if (ops[j].is_d) e_dfwe = 1; else e_ifwe = 1;
        end
        if (k == MEM_LAT + 7) begin
          if (ops[j].is_d) e_ddone = 1; else e_idone = 1;
        end
      end
    end
    chk("mem_en", mem_en, e_en);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("i_fill_we", i_fill_we, e_ifwe);
    chk("d_fill_we", d_fill_we, e_dfwe);
    chk("i_done", i_done, e_idone);
    chk("d_done", d_done, e_ddone);
    chk("i_stall", i_stall, i_req & ~e_idone);
    chk("d_stall", d_stall, d_req & ~e_ddone);
  endtask

  task automatic check_zero(input logic ei, input logic ed);
    chk("z_mem_en", mem_en, 0);   chk("z_mem_wr", mem_wr, 0);
    chk("z_mem_addr", mem_addr, 0); chk("z_mem_wdata", mem_wdata, 0);
    chk("z_i_fill_we", i_fill_we, 0); chk("z_d_fill_we", d_fill_we, 0);
    chk("z_fill_addr", fill_addr, 0); chk("z_fill_data", fill_data, 0);
    chk("z_i_done", i_done, 0);   chk("z_d_done", d_done, 0);
    chk("z_i_stall", i_stall, ei); chk("z_d_stall", d_stall, ed);
  endtask

  task automatic push_fills();
    fill_t f;
    foreach (ops[j]) if (!ops[j].wr) begin
      for (int w = 0; w < 8; w++) begin
        f.is_d = ops[j].is_d;
        f.addr = ops[j].base + 16'(2 * w);
        f.data = mem_model(f.addr);
        sb.push_back(f);
      end
    end
  endtask

  task automatic run_cycles(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      @(posedge clk); #1;
      foreach (evs[j]) if (evs[j].cyc == c) begin
        if (evs[j].is_d) begin
          d_req = evs[j].on;
          if (evs[j].on) begin d_addr = evs[j].addr; d_wr = evs[j].wr; d_wdata = evs[j].wdata; end
        end else begin
          i_req = evs[j].on;
          if (evs[j].on) i_addr = evs[j].addr;
        end
      end
      @(negedge clk);
      check_cycle(c);
    end
  endtask

  task automatic run(input int ncyc);
    push_fills();
    run_cycles(0, ncyc);
    chk("sb_drain", sb.size(), 0);
    ops.delete();
    evs.delete();
  endtask

  typedef struct { bit is_d; bit wr; logic [15:0] addr; logic [15:0] wdata; logic [15:0] exp_base; int exp_done; } vec_t;
  vec_t tbl [6];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'h1230, 12};
    tbl[1] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0100, 12};
    tbl[2] = '{1'b1, 1'b1, 16'h0042, 16'hBEEF, 16'h0042, 1};
    tbl[3] = '{1'b1, 1'b0, 16'h000F, 16'h0000, 16'h0000, 12};
    tbl[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFF0, 12};
    tbl[5] = '{1'b1, 1'b1, 16'hFFFE, 16'h1234, 16'hFFFE, 1};

    rst_n = 0; i_req = 0; d_req = 0; d_wr = 0; inj_valid = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    repeat (2) @(negedge clk);
    check_zero(0, 0);
    i_req = 1; #1;
    check_zero(1, 0);
    i_req = 0;
    @(posedge clk); #1 rst_n = 1;

    // Both requests right after reset: D first, then I.
    add_op(1, 1, 0, 16'h2000, 16'h2000, 0);
    add_op(14, 0, 0, 16'h0100, 16'h0100, 0);
    add_ev(0, 1, 1, 16'h2000, 0, 0);
    add_ev(0, 0, 1, 16'h0100, 0, 0);
    add_ev(13, 1, 0, 0, 0, 0);
    add_ev(26, 0, 0, 0, 0, 0);
    run(26);

    // Continuous re-requesting: D, I, D, I, D, then a tie after a D grant goes to I.
    add_op(1, 1, 1, 16'h0400, 16'h0400, 16'h5A5A);
    add_op(3, 0, 0, 16'h0300, 16'h0300, 0);
    add_op(16, 1, 1, 16'h0406, 16'h0406, 16'h1111);
    add_op(18, 0, 0, 16'h0310, 16'h0310, 0);
    add_op(31, 1, 1, 16'h040A, 16'h040A, 16'h2222);
    add_op(34, 0, 0, 16'h0327, 16'h0320, 0);
    add_op(47, 1, 1, 16'h040C, 16'h040C, 16'h3333);
    add_ev(0, 0, 1, 16'h0300, 0, 0);
    add_ev(0, 1, 1, 16'h0400, 1, 16'h5A5A);
    add_ev(2, 1, 0, 0, 0, 0);
    add_ev(3, 1, 1, 16'h0406, 1, 16'h1111);
    add_ev(15, 0, 0, 0, 0, 0);
    add_ev(16, 0, 1, 16'h0310, 0, 0);
    add_ev(17, 1, 0, 0, 0, 0);
    add_ev(19, 1, 1, 16'h040A, 1, 16'h2222);
    add_ev(30, 0, 0, 0, 0, 0);
    add_ev(32, 1, 0, 0, 0, 0);
    add_ev(33, 0, 1, 16'h0327, 0, 0);
    add_ev(33, 1, 1, 16'h040C, 1, 16'h3333);
    add_ev(46, 0, 0, 0, 0, 0);
    add_ev(48, 1, 0, 0, 0, 0);
    run(48);

    // Single-transaction vectors.
    for (int t = 0; t < 6; t++) begin
      add_op(1, tbl[t].is_d, tbl[t].wr, tbl[t].addr, tbl[t].exp_base, tbl[t].wdata);
      add_ev(0, tbl[t].is_d, 1, tbl[t].addr, tbl[t].wr, tbl[t].wdata);
      add_ev(tbl[t].exp_done + 1, tbl[t].is_d, 0, 0, 0, 0);
      run(tbl[t].exp_done + 1);
    end

    // Reset in cycle 6 of a D fill; stale returns must be ignored.
    add_op(1, 1, 0, 16'h3000, 16'h3000, 0);
    add_ev(0, 1, 1, 16'h3000, 0, 0);
    push_fills();
    run_cycles(0, 5);
    @(posedge clk); #1 rst_n = 0;
    sb.delete();
    @(negedge clk);
    cur_cyc = 6;
    check_zero(0, 1);
    @(posedge clk); #1 d_req = 0; rst_n = 1;
    ops.delete(); evs.delete();
    run(6);
    add_op(1, 0, 0, 16'h0708, 16'h0700, 0);
    add_ev(0, 0, 1, 16'h0708, 0, 0);
    add_ev(13, 0, 0, 0, 0, 0);
    run(13);

    // Spurious mem_valid in IDLE, then a D fill whose request drops in cycle 3.
    @(posedge clk); #1 inj_valid = 1;
    @(negedge clk);
    chk("spur_i_fill_we", i_fill_we, 0);
    chk("spur_d_fill_we", d_fill_we, 0);
    chk("spur_fill_data", fill_data, 0);
    @(posedge clk); #1 inj_valid = 0;
    add_op(1, 1, 0, 16'h4008, 16'h4000, 0);
    add_ev(0, 1, 1, 16'h4008, 0, 0);
    add_ev(3, 1, 0, 0, 0, 0);
    run(13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
